// File: rtl/pc_seq_ctrl_if.sv
// Instruction-fetch request bus between the PC sequencer (master) and the
// instruction memory (slave).
interface pc_seq_ctrl_if;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;

  modport master (
    output fetch_valid,
    output fetch_addr,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    output fetch_ready
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// PC sequencer with FENCE drain control and an outstanding data-memory op counter.
// Define PC_SEQ_FENCE_PERF_EN to build the cumulative DRAIN-cycle counter (fence_cycles).
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_seq_ctrl_if.master        fetch_bus,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 stall,
  input  logic                 fence_req,
  input  logic                 mem_issue,
  input  logic                 mem_done,
  output logic                 mem_issue_ok,
  output logic                 fence_busy,
  output logic [31:0]          predecessor,
  output logic [31:0]          successor,
  output logic [3:0]           outstanding,
  output logic                 cnt_err,
  output logic [31:0]          fence_cycles
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pend_valid;
  logic        pend_valid_next;
  logic [31:0] pend_pc;
  logic [31:0] pend_pc_next;
  logic [31:0] pred_next;
  logic [31:0] succ_next;
  logic [31:0] redirect_target;
  logic        fetch_fire;
  logic        drain_exit;

  assign redirect_target        = {redirect_pc[31:2], 2'b00};
  assign fetch_bus.fetch_valid  = (state == RUN) && !stall;
  assign fetch_bus.fetch_addr   = pc;
  assign fetch_fire             = (state == RUN) && !stall && fetch_bus.fetch_ready;
  assign fence_busy             = (state == DRAIN);
  assign mem_issue_ok           = (outstanding < MAX_CNT);
  // The fence may only retire once nothing is in flight and nothing new is launching.
  assign drain_exit             = (outstanding == 4'd0) && !mem_issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_pc     <= 32'h0;
      predecessor <= 32'h0;
      successor   <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_valid  <= pend_valid_next;
      pend_pc     <= pend_pc_next;
      predecessor <= pred_next;
      successor   <= succ_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pend_valid_next = pend_valid;
    pend_pc_next    = pend_pc;
    pred_next       = predecessor;
    succ_next       = successor;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        // A fence wins over a same-cycle redirect; the redirect is parked until the drain ends.
        if (fence_req) begin
          pred_next  = pc;
          succ_next  = pc + 32'd4;
          state_next = DRAIN;
          if (redirect_valid) begin
            pend_valid_next = 1'b1;
            pend_pc_next    = redirect_target;
          end
        end else if (redirect_valid) begin
          pc_next = redirect_target;
        end else if (fetch_fire) begin
          pc_next = pc + 32'd4;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pend_valid_next = 1'b1;
          pend_pc_next    = redirect_target;
        end
        if (drain_exit) begin
          if (redirect_valid) begin
            pc_next = redirect_target;
          end else if (pend_valid) begin
            pc_next = pend_pc;
          end else begin
            pc_next = successor;
          end
          pend_valid_next = 1'b0;
          state_next      = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // Saturating outstanding-op counter; a dropped event latches the sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= 4'd0;
      cnt_err     <= 1'b0;
    end else if (mem_issue && !mem_done) begin
      if (outstanding == MAX_CNT) begin
        cnt_err <= 1'b1;
      end else begin
        outstanding <= outstanding + 4'd1;
      end
    end else if (mem_done && !mem_issue) begin
      if (outstanding == 4'd0) begin
        cnt_err <= 1'b1;
      end else begin
        outstanding <= outstanding - 4'd1;
      end
    end
  end

`ifdef PC_SEQ_FENCE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fence_cycles <= 32'h0;
    end else if (state == DRAIN) begin
      fence_cycles <= fence_cycles + 32'd1;
    end
  end
`else
  assign fence_cycles = 32'h0;
`endif

endmodule
